// File: rtl/oled_pkg.sv
// Shared types and geometry for the SSD1306 seven-segment row renderer.
// Holds the per-digit segment word, the frame FSM states and the pixel coverage rule.
package oled_pkg;

  localparam int unsigned SSD1306_PAGE_ROWS = 8;
  localparam int unsigned SSD1306_MAX_PAGES = 8;

  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  typedef union packed {
    seg_bits_t  individual;
    logic [6:0] raw;
  } Segments;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

  // True when any enabled segment covers pixel (lx, r) of a w x h digit with stroke t.
  function automatic logic pixel_lit(
    input Segments     s,
    input int unsigned lx,
    input int unsigned r,
    input int unsigned w,
    input int unsigned h,
    input int unsigned t
  );
    int unsigned half;
    int unsigned g_top;
    logic        upper;
    logic        left;
    logic        right;
    half  = h / 32'd2;
    g_top = half - t / 32'd2;
    upper = (r < half);
    left  = (lx < t);
    right = (lx >= w - t);
    pixel_lit = (lx < w) & (
                  (s.individual.a & (r < t))
                | (s.individual.d & (r >= h - t))
                | (s.individual.g & (r >= g_top) & (r < g_top + t))
                | (s.individual.f & left  &  upper)
                | (s.individual.e & left  & ~upper)
                | (s.individual.b & right &  upper)
                | (s.individual.c & right & ~upper));
  endfunction

endpackage

// File: rtl/seg7_column_slice.sv
// Combinational 8-pixel column slice of one seven-segment digit.
// Bit n of column is row page*8+n of the digit, LSB on top.
module seg7_column_slice
  import oled_pkg::*;
#(
  parameter int unsigned W         = 19,
  parameter int unsigned PAGES     = 4,
  parameter int unsigned SEG_THICK = 3,
  parameter int unsigned LX_W      = (W > 1) ? $clog2(W) : 1,
  parameter int unsigned PAGE_W    = $clog2(SSD1306_MAX_PAGES)
) (
  input  Segments           segments,
  input  logic [LX_W-1:0]   lx,
  input  logic [PAGE_W-1:0] page,
  output logic [7:0]        column
);

  // Evaluate the coverage rule for each of the eight rows in this page.
  always_comb begin
    column = 8'h00;
    for (int unsigned n = 0; n < SSD1306_PAGE_ROWS; n++) begin
      column[n] = pixel_lit(segments, 32'(lx), 32'(page) * SSD1306_PAGE_ROWS + n,
                            W, PAGES * SSD1306_PAGE_ROWS, SEG_THICK);
    end
  end

endmodule

// File: rtl/seg7_digit_row_streamer.sv
// Streams a latched row of seven-segment digits as SSD1306 page-mode bytes
// (page, digit, column order) through a single valid/ready output register.
module seg7_digit_row_streamer
  import oled_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_WIDTH = 21,
  parameter int unsigned SPACE       = 2,
  parameter int unsigned PAGES       = 4,
  parameter int unsigned SEG_THICK   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_DIGITS*7-1:0] segments_in,
  input  logic                    invert,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_page_start
);

  localparam int unsigned W      = DIGIT_WIDTH - SPACE;
  localparam int unsigned COL_W  = (DIGIT_WIDTH > 1) ? $clog2(DIGIT_WIDTH) : 1;
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PAGE_W = $clog2(SSD1306_MAX_PAGES);
  localparam int unsigned LX_W   = (W > 1) ? $clog2(W) : 1;

  frame_state_t      state_r;
  frame_state_t      state_next_s;
  logic [COL_W-1:0]  col_r;
  logic [DIG_W-1:0]  digit_r;
  logic [PAGE_W-1:0] page_r;
  Segments           seg_latch_r [NUM_DIGITS];
  logic              invert_r;
  logic              busy_r;
  logic              done_r;
  logic [7:0]        out_data_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              out_page_start_r;

  logic              start_ok_s;
  logic              load_s;
  logic              hs_s;
  logic              col_end_s;
  logic              digit_end_s;
  logic              last_pos_s;
  logic              blank_s;
  logic [LX_W-1:0]   lx_s;
  logic [7:0]        slice_s;
  logic [7:0]        pixel_byte_s;

  // A start landing in the done cycle is dropped so frames are separated by a cycle.
  assign start_ok_s   = (state_r == IDLE) && !done_r && start;
  assign load_s       = (state_r == LOAD) && (!out_valid_r || out_ready);
  assign hs_s         = out_valid_r && out_ready;
  assign col_end_s    = (col_r == COL_W'(DIGIT_WIDTH - 1));
  assign digit_end_s  = (digit_r == DIG_W'(NUM_DIGITS - 1));
  assign last_pos_s   = col_end_s && digit_end_s && (page_r == PAGE_W'(PAGES - 1));
  assign blank_s      = (col_r < COL_W'(SPACE));
  assign lx_s         = blank_s ? {LX_W{1'b0}} : LX_W'(col_r - COL_W'(SPACE));
  assign pixel_byte_s = (blank_s ? 8'h00 : slice_s) ^ {8{invert_r}};

  seg7_column_slice #(
    .W         (W),
    .PAGES     (PAGES),
    .SEG_THICK (SEG_THICK),
    .LX_W      (LX_W),
    .PAGE_W    (PAGE_W)
  ) u_slice (
    .segments (seg_latch_r[digit_r]),
    .lx       (lx_s),
    .page     (page_r),
    .column   (slice_s)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame sequencing: load bytes until the last position, then wait for its handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        if (load_s && last_pos_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = LOAD;
        end
      end
      DRAIN: begin
        if (hs_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Input latch, position counters, output register and busy/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r            <= {COL_W{1'b0}};
      digit_r          <= {DIG_W{1'b0}};
      page_r           <= {PAGE_W{1'b0}};
      invert_r         <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      out_data_r       <= 8'h00;
      out_valid_r      <= 1'b0;
      out_last_r       <= 1'b0;
      out_page_start_r <= 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        seg_latch_r[k] <= 7'h00;
      end
    end else begin
      done_r <= 1'b0;
      if (start_ok_s) begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          seg_latch_r[k] <= segments_in[k*7 +: 7];
        end
        invert_r <= invert;
        busy_r   <= 1'b1;
        col_r    <= {COL_W{1'b0}};
        digit_r  <= {DIG_W{1'b0}};
        page_r   <= {PAGE_W{1'b0}};
      end
      if (load_s) begin
        out_data_r       <= pixel_byte_s;
        out_valid_r      <= 1'b1;
        out_last_r       <= last_pos_s;
        out_page_start_r <= (col_r == {COL_W{1'b0}}) && (digit_r == {DIG_W{1'b0}});
        if (col_end_s) begin
          col_r <= {COL_W{1'b0}};
          if (digit_end_s) begin
            digit_r <= {DIG_W{1'b0}};
            if (last_pos_s) begin
              page_r <= {PAGE_W{1'b0}};
            end else begin
              page_r <= page_r + PAGE_W'(1);
            end
          end else begin
            digit_r <= digit_r + DIG_W'(1);
          end
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end else if ((state_r == DRAIN) && hs_s) begin
        out_valid_r      <= 1'b0;
        out_last_r       <= 1'b0;
        out_page_start_r <= 1'b0;
        busy_r           <= 1'b0;
        done_r           <= 1'b1;
      end
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign out_data       = out_data_r;
  assign out_valid      = out_valid_r;
  assign out_last       = out_last_r;
  assign out_page_start = out_page_start_r;

endmodule

// File: tb/tb_seg7_digit_row_streamer.sv
// Scoreboard bench for seg7_digit_row_streamer: stimulus pushes hand-computed bytes
// keyed by frame position, a negedge monitor pops and compares on every handshake.
module tb_seg7_digit_row_streamer;

  localparam int FRAME      = 336;
  localparam int PAGE_BYTES = 84;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [27:0] segments_in;
  logic        invert;
  logic        busy;
  logic        done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_page_start;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests       = 0;
  int   fails       = 0;
  int   byte_idx    = 0;
  int   frames_done = 0;
  bit   want_done   = 1'b0;

  seg7_digit_row_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .segments_in    (segments_in),
    .invert         (invert),
    .busy           (busy),
    .done           (done),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .out_page_start (out_page_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (byte %0d)", name, act, exp, byte_idx);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake is one frame byte; done must follow the last one.
  always @(negedge clk) begin
    if (reset) begin
      byte_idx  = 0;
      want_done = 1'b0;
      exp_q.delete();
    end else begin
      if (want_done) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        check("frame_len", 32'(byte_idx), 32'(FRAME));
        check("missing_bytes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        byte_idx  = 0;
        want_done = 1'b0;
        frames_done++;
      end
      if (out_valid && out_ready) begin
        check("page_start", 32'(out_page_start), 32'((byte_idx % PAGE_BYTES) == 0));
        check("last_flag", 32'(out_last), 32'(byte_idx == FRAME - 1));
        while (exp_q.size() > 0 && exp_q[0].idx == byte_idx) begin
          mon_e = exp_q.pop_front();
          check("pixel_byte", 32'(out_data), 32'(mon_e.data));
        end
        if (out_last) begin
          want_done = 1'b1;
        end
        byte_idx++;
      end
    end
  end

  task automatic do_start(input logic [6:0] seg, input logic inv);
    segments_in = {4{seg}};
    invert      = inv;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    segments_in = 28'h0000000;
    invert      = ~inv;
  endtask

  task automatic wait_frame(input int f0);
    int n;
    n = 0;
    while (frames_done == f0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frame_done", 32'(frames_done), 32'(f0 + 1));
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (byte_idx != target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_byte", 32'(byte_idx), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         f0;
    int         n;
    logic [7:0] held_data;
    logic       held_last;
    logic       held_ps;

    reset       = 1'b1;
    start       = 1'b0;
    invert      = 1'b0;
    out_ready   = 1'b1;
    segments_in = 28'h0000000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_page_start", 32'(out_page_start), 32'd0);

    // All segments lit
    push_exp(0, 8'h00);   push_exp(1, 8'h00);   push_exp(2, 8'hFF);
    push_exp(7, 8'h07);   push_exp(65, 8'hFF);  push_exp(91, 8'h80);
    push_exp(175, 8'h03); push_exp(259, 8'hE0); push_exp(322, 8'hE0);
    f0 = frames_done;
    do_start(7'h7F, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_frame(f0);

    // Blank digits, inverted
    for (int i = 0; i < FRAME; i++) push_exp(i, 8'hFF);
    f0 = frames_done;
    do_start(7'h00, 1'b1);
    wait_frame(f0);

    // Backpressure on byte 40
    push_exp(38, 8'h07); push_exp(39, 8'hFF); push_exp(40, 8'hFF); push_exp(41, 8'hFF);
    push_exp(42, 8'h00); push_exp(43, 8'h00); push_exp(44, 8'hFF); push_exp(45, 8'hFF);
    push_exp(46, 8'hFF); push_exp(47, 8'h07);
    f0 = frames_done;
    do_start(7'h7F, 1'b0);
    wait_bytes(39);
    out_ready = 1'b0;
    held_data = out_data;
    held_last = out_last;
    held_ps   = out_page_start;
    check("stall_byte40", 32'(held_data), 32'hFF);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(held_data));
      check("stall_last", 32'(out_last), 32'(held_last));
      check("stall_ps", 32'(out_page_start), 32'(held_ps));
      check("stall_count", 32'(byte_idx), 32'd39);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_frame(f0);

    // Digit "1": segments b and c
    push_exp(0, 8'h00);  push_exp(10, 8'h00); push_exp(20, 8'hFF);
    push_exp(104, 8'hFF); push_exp(272, 8'hFF);
    f0 = frames_done;
    do_start(7'h06, 1'b0);
    wait_frame(f0);

    // Reset after byte 100, then restart
    push_exp(2, 8'hFF); push_exp(7, 8'h07);
    do_start(7'h7F, 1'b0);
    wait_bytes(100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    push_exp(0, 8'h00); push_exp(2, 8'hFF); push_exp(91, 8'h80); push_exp(259, 8'hE0);
    f0 = frames_done;
    do_start(7'h7F, 1'b0);
    wait_frame(f0);

    // Starts while busy and in the done cycle are ignored
    push_exp(2, 8'hFF); push_exp(259, 8'hE0);
    f0 = frames_done;
    do_start(7'h7F, 1'b0);
    repeat (3) begin
      segments_in = 28'h0000000;
      invert      = 1'b1;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
    end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    segments_in = {4{7'h7F}};
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ignored_busy", 32'(busy), 32'd0);
    check("ignored_valid", 32'(out_valid), 32'd0);
    check("one_frame", 32'(frames_done), 32'(f0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
